// File: rtl/arithmetic.sv
// ---------------------------------------------------------------------------
// arithmetic : registered 8-bit arithmetic unit with one 16-bit result port
//              per operation (add, sub, mul, div). One clock of latency.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   enable_low  0 = compute on this edge, 1 = hold results, valid drops
//   P           operation select: 00 add, 01 sub, 10 mul, 11 div
//   A, B        8-bit operands (A = minuend/dividend, B = subtrahend/divisor)
//   y1..y4      add / sub / mul / div results; y4 = {remainder, quotient}
//   valid       high for the cycle after each enabled operation
//   err         divide error flag for the current result
//
// Configuration
//   ARITHMETIC_SIGNED_EN : when defined, A and B are two's-complement values.
//                          Division truncates toward zero, and -128 / -1
//                          raises err.
// ---------------------------------------------------------------------------
module arithmetic (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_low,
   input  logic [1:0]  P,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] y1,
   output logic [15:0] y2,
   output logic [15:0] y3,
   output logic [15:0] y4,
   output logic        valid,
   output logic        err
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   logic [15:0] y1_q, y2_q, y3_q, y4_q;
   logic [15:0] y1_d, y2_d, y3_d, y4_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [15:0] add_res, sub_res, mul_res, div_res;
   logic        div_err;

`ifdef ARITHMETIC_SIGNED_EN
   logic signed [15:0] a_s, b_s, b_safe_s, quot_s, rem_s;

   always_comb begin
      a_s      = {{8{A[7]}}, A};
      b_s      = {{8{B[7]}}, B};
      // Divide by one when B is zero so the simulator never sees x/0.
      b_safe_s = (B == 8'h00) ? 16'sd1 : b_s;
      add_res  = a_s + b_s;
      sub_res  = a_s - b_s;
      mul_res  = a_s * b_s;
      // At 16 bits -128 / -1 = +128, whose low byte is 8'h80 with remainder 0,
      // so the overflow case needs only the error flag.
      quot_s   = a_s / b_safe_s;
      rem_s    = a_s % b_safe_s;
      div_err  = (B == 8'h00) || (A == 8'h80 && B == 8'hFF);
      div_res  = (B == 8'h00) ? 16'hFFFF : {rem_s[7:0], quot_s[7:0]};
   end
`else
   logic [7:0] b_safe;

   always_comb begin
      // Divide by one when B is zero so the simulator never sees x/0.
      b_safe  = (B == 8'h00) ? 8'd1 : B;
      add_res = {8'h00, A} + {8'h00, B};
      sub_res = {8'h00, A} - {8'h00, B};
      mul_res = {8'h00, A} * {8'h00, B};
      div_err = (B == 8'h00);
      div_res = div_err ? 16'hFFFF : {A % b_safe, A / b_safe};
   end
`endif

   always_comb begin
      // NOTE: every _d gets a default first, so no path leaves it unassigned
      // and no latch is inferred.
      y1_d    = y1_q;
      y2_d    = y2_q;
      y3_d    = y3_q;
      y4_d    = y4_q;
      err_d   = err_q;
      valid_d = 1'b0;

      if (!enable_low) begin
         // Only the selected port carries a result; the rest read zero.
         y1_d    = 16'h0000;
         y2_d    = 16'h0000;
         y3_d    = 16'h0000;
         y4_d    = 16'h0000;
         err_d   = 1'b0;
         valid_d = 1'b1;
         case (op_e'(P))
            OP_ADD: y1_d = add_res;
            OP_SUB: y2_d = sub_res;
            OP_MUL: y3_d = mul_res;
            OP_DIV: begin
               y4_d  = div_res;
               err_d = div_err;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y1_q    <= 16'h0000;
         y2_q    <= 16'h0000;
         y3_q    <= 16'h0000;
         y4_q    <= 16'h0000;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         y1_q    <= y1_d;
         y2_q    <= y2_d;
         y3_q    <= y3_d;
         y4_q    <= y4_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign y1    = y1_q;
   assign y2    = y2_q;
   assign y3    = y3_q;
   assign y4    = y4_q;
   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_arithmetic.sv
// ---------------------------------------------------------------------------
// tb_arithmetic : directed, self-checking bench for arithmetic.
// Each observation packs {y1, y2, y3, y4, valid, err} into one 66-bit word and
// compares it with a hand-computed expected word.
// ---------------------------------------------------------------------------
module tb_arithmetic;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_low;
   logic [1:0]  P;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] y1, y2, y3, y4;
   logic        valid, err;

   int total = 0;
   int bad   = 0;

   arithmetic dut (
      .clk        (clk),
      .rst        (rst),
      .enable_low (enable_low),
      .P          (P),
      .A          (A),
      .B          (B),
      .y1         (y1),
      .y2         (y2),
      .y3         (y3),
      .y4         (y4),
      .valid      (valid),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] pack(input logic [15:0] a1, a2, a3, a4,
                                        input logic v, e);
      return {a1, a2, a3, a4, v, e};
   endfunction

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [65:0] got;
      // Put something non-zero in the registers first.
      rst = 1'b0; enable_low = 1'b0; P = 2'b00; A = 8'd3; B = 8'd4;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0007, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL pre_reset_add got=%h want=%h", got,
                  pack(16'h0007, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0));
      end
      // Assert reset mid-cycle; outputs must clear with no clock edge.
      #2 rst = 1'b1;
      #1;
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== 66'h0) begin
         bad++;
         $display("FAIL async_reset got=%h want=%h", got, 66'h0);
      end
      // Held through an edge while rst is high, even with enable asserted.
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== 66'h0) begin
         bad++;
         $display("FAIL reset_hold got=%h want=%h", got, 66'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      enable_low = 1'b1;
   endtask

   task automatic test_ops();
      logic [65:0] got;
      logic [65:0] want [4];
`ifdef ARITHMETIC_SIGNED_EN
      // 2 and -128: add -126, sub 130, mul -256, div q=0 r=2.
      want[0] = pack(16'hFF82, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      want[1] = pack(16'h0, 16'h0082, 16'h0, 16'h0, 1'b1, 1'b0);
      want[2] = pack(16'h0, 16'h0, 16'hFF00, 16'h0, 1'b1, 1'b0);
`else
      want[0] = pack(16'h0082, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      want[1] = pack(16'h0, 16'hFF82, 16'h0, 16'h0, 1'b1, 1'b0);
      want[2] = pack(16'h0, 16'h0, 16'h0100, 16'h0, 1'b1, 1'b0);
`endif
      want[3] = pack(16'h0, 16'h0, 16'h0, 16'h0200, 1'b1, 1'b0);
      A = 8'd2; B = 8'd128; enable_low = 1'b0;
      for (int i = 0; i < 4; i++) begin
         P = 2'(i);
         tick();
         got = pack(y1, y2, y3, y4, valid, err);
         total++;
         if (got !== want[i]) begin
            bad++;
            $display("FAIL op_P%0d got=%h want=%h", i, got, want[i]);
         end
      end
   endtask

   task automatic test_hold();
      logic [65:0] got;
      logic [65:0] want;
      want = pack(16'h0, 16'h0, 16'h0, 16'h0200, 1'b0, 1'b0);
      enable_low = 1'b1; P = 2'b00; A = 8'd5;
      for (int i = 0; i < 2; i++) begin
         tick();
         got = pack(y1, y2, y3, y4, valid, err);
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL hold_%0d got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [65:0] got;
      A = 8'd7; B = 8'd0; P = 2'b11; enable_low = 1'b0;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b1, 1'b1)) begin
         bad++;
         $display("FAIL div_zero got=%h want=%h", got,
                  pack(16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b1, 1'b1));
      end
      // err and y4 hold while disabled, even with new inputs.
      enable_low = 1'b1; A = 8'd9; B = 8'd3; P = 2'b10;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL err_hold got=%h want=%h", got,
                  pack(16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b0, 1'b1));
      end
      A = 8'd1; B = 8'd1; P = 2'b00; enable_low = 1'b0;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0002, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL err_clear got=%h want=%h", got,
                  pack(16'h0002, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0));
      end
   endtask

   task automatic test_extremes();
      logic [65:0] got;
      logic [65:0] want [3];
      logic [1:0]  ops  [3];
      ops[0] = 2'b10; ops[1] = 2'b00; ops[2] = 2'b11;
`ifdef ARITHMETIC_SIGNED_EN
      // -1 and -1: mul 1, add -2, div q=1 r=0.
      want[0] = pack(16'h0, 16'h0, 16'h0001, 16'h0, 1'b1, 1'b0);
      want[1] = pack(16'hFFFE, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
`else
      want[0] = pack(16'h0, 16'h0, 16'hFE01, 16'h0, 1'b1, 1'b0);
      want[1] = pack(16'h01FE, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
`endif
      want[2] = pack(16'h0, 16'h0, 16'h0, 16'h0001, 1'b1, 1'b0);
      A = 8'hFF; B = 8'hFF; enable_low = 1'b0;
      for (int i = 0; i < 3; i++) begin
         P = ops[i];
         tick();
         got = pack(y1, y2, y3, y4, valid, err);
         total++;
         if (got !== want[i]) begin
            bad++;
            $display("FAIL extreme_%0d got=%h want=%h", i, got, want[i]);
         end
      end
      // Unsigned 0 - 255 wraps to 16'hFF01 (signed: 0 - (-1) = 1).
      A = 8'h00; B = 8'hFF; P = 2'b01;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
`ifdef ARITHMETIC_SIGNED_EN
      if (got !== pack(16'h0, 16'h0001, 16'h0, 16'h0, 1'b1, 1'b0)) begin
`else
      if (got !== pack(16'h0, 16'hFF01, 16'h0, 16'h0, 1'b1, 1'b0)) begin
`endif
         bad++;
         $display("FAIL sub_wrap got=%h", got);
      end
      // Divide with non-zero remainder: 200 / 7 = 28 r 4 (signed: -56/7 = -8 r 0).
      A = 8'd200; B = 8'd7; P = 2'b11;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
`ifdef ARITHMETIC_SIGNED_EN
      if (got !== pack(16'h0, 16'h0, 16'h0, 16'h00F8, 1'b1, 1'b0)) begin
`else
      if (got !== pack(16'h0, 16'h0, 16'h0, 16'h041C, 1'b1, 1'b0)) begin
`endif
         bad++;
         $display("FAIL div_rem got=%h", got);
      end
   endtask

`ifdef ARITHMETIC_SIGNED_EN
   task automatic test_signed();
      logic [65:0] got;
      A = 8'hFE; B = 8'h03; enable_low = 1'b0; P = 2'b10;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0, 16'h0, 16'hFFFA, 16'h0, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL signed_mul got=%h", got);
      end
      P = 2'b11;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0, 16'h0, 16'h0, 16'hFE00, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL signed_div got=%h", got);
      end
      A = 8'h80; B = 8'hFF;
      tick();
      got = pack(y1, y2, y3, y4, valid, err);
      total++;
      if (got !== pack(16'h0, 16'h0, 16'h0, 16'h0080, 1'b1, 1'b1)) begin
         bad++;
         $display("FAIL signed_ovf got=%h", got);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; enable_low = 1'b1; P = 2'b00; A = 8'h00; B = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_ops();
      test_hold();
      test_div_zero();
      test_extremes();
`ifdef ARITHMETIC_SIGNED_EN
      test_signed();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arithmetic.md
Name: arithmetic

Overview:
- Registered 8-bit arithmetic unit with four dedicated 16-bit result ports: add, subtract, multiply and divide.
- The 2-bit select P picks the one operation evaluated on each enabled clock.
- Enable is active-low.
- Sits in the datapath as a small single-cycle compute leaf. Upstream logic drives operands and select; downstream samples the y-port matching the select once valid is high.

Parameters:
- None. Operand width is fixed at 8 and result width at 16.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- enable_low  input  1  active-low operation enable; 0 = compute, 1 = hold.
- P  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
- A  input  8  operand A (dividend / minuend).
- B  input  8  operand B (divisor / subtrahend).
- y1  output  16  add result.
- y2  output  16  subtract result.
- y3  output  16  multiply result.
- y4  output  16  divide result: {remainder[7:0], quotient[7:0]}.
- valid  output  1  high for the cycle after each enabled operation.
- err  output  1  divide error flag for the current result.

Behaviour:
- Reset (async, rst=1): y1..y4 = 16'h0000, valid = 0, err = 0. Outputs are held while rst is high. Reset mid-operation discards the pending result.
- Latency: 1 clock. Inputs are sampled on a rising clk with enable_low=0; results appear after that edge.
- Enabled edge (enable_low=0):
  - Only the selected y-port is updated. The other three y-ports are cleared to 0, so exactly one port carries a result.
  - valid <= 1.
- Disabled edge (enable_low=1): all y-ports and err hold their values; valid <= 0.
- P=00: y1 = zero-extended A + zero-extended B. Range 0..510, no overflow.
- P=01: y2 = A - B computed in 16-bit two's complement, wrapping. Example: 2 - 128 = 16'hFF82.
- P=10: y3 = A * B, full 16-bit product, no overflow.
- P=11, B != 0: y4[7:0] = A / B (floor), y4[15:8] = A % B, err = 0.
- P=11, B == 0: y4 = 16'hFFFF and err = 1.
- err is cleared to 0 on every enabled edge that is not a divide error.
- Division is combinational within the cycle (no multicycle divider), so the result is valid after one edge.
- Changing P or the operands while disabled has no effect on any output.

Optional Feature:
- Macro ARITHMETIC_SIGNED_EN. When defined, A and B are 8-bit two's-complement values:
  - Add and sub results are sign-extended to 16 bits.
  - Multiply gives the signed 16-bit product.
  - Divide truncates toward zero; the remainder takes the sign of the dividend.
  - -128 / -1 yields y4 = {8'h00, 8'h80} with err = 1.
  - B == 0 still gives y4 = 16'hFFFF, err = 1.
- When not defined, all arithmetic is unsigned as described above.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> y1..y4 = 0, valid = 0, err = 0 immediately, before any clock edge.
- A=8'd2, B=8'd128, enable_low=0; step P through 00, 01, 10, 11 on successive edges. Each following cycle must show, with the other three y-ports at 0 and valid = 1:
  - y1 = 16'h0082
  - y2 = 16'hFF82
  - y3 = 16'h0100
  - y4 = 16'h0200
- Hold: after the P=11 result, set enable_low=1 and change P to 00 and A to 8'd5 -> y4 stays 16'h0200, y1 stays 0, valid = 0.
- Divide by zero: A=8'd7, B=0, P=11, enable_low=0 -> y4 = 16'hFFFF, err = 1. The next enabled add with A=1, B=1 gives y1 = 16'h0002, err = 0, y4 = 0.
- Extremes: A=B=8'hFF, P=10 -> y3 = 16'hFE01. With P=00 -> y1 = 16'h01FE. With P=11 -> y4 = 16'h0001.
- Signed build (ARITHMETIC_SIGNED_EN): A=8'hFE (-2), B=8'h03:
  - P=10 -> y3 = 16'hFFFA
  - P=11 -> y4 = {8'hFE, 8'h00}, i.e. quotient 0, remainder -2
  - A=8'h80, B=8'hFF, P=11 -> y4 = 16'h0080, err = 1
